ioctl_sdram_loader: RTL
=======================

Name: ioctl_sdram_loader

Overview:
- Sits between hps_io's ioctl download port and the sdram controller's request port.
- Packs the byte-serial ROM stream into 32-bit little-endian words and writes them to SDRAM through the req/ack handshake.
- Asserts ioctl_wait to throttle hps_io while a write is pending.
- The game core keeps SDRAM reads; this block owns the write path only while ioctl_download is high.

Parameters:
BASE_ADDR, 23'h000000, word address added to ioctl_addr[24:2]
PAD_BYTE, 8'hFF, value written into byte lanes not supplied before a flush
ADDR_WIDTH, 23, SDRAM word-address width

Ports:
clk  in  1  system clock (48 MHz clk_sys)
reset_n  in  1  asynchronous active-low reset
ioctl_addr  in  25  byte address of the current download byte
ioctl_data  in  8  download byte
ioctl_wr  in  1  one-cycle strobe, byte valid
ioctl_download  in  1  high for the whole download
ioctl_wait  out  1  high = hps_io must hold off the next ioctl_wr
sdram_addr  out  ADDR_WIDTH  word address
sdram_data  out  32  write word; byte at ioctl_addr[1:0]=n goes to bits 8n+7:8n
sdram_we  out  1  write enable (always 1 while sdram_req is high)
sdram_req  out  1  request
sdram_ack  in  1  one-cycle pulse: request accepted
done  out  1  one-cycle pulse after the last word is written once download falls
words_written  out  23  count of words committed this download

Behaviour:
Reset (async assert, sync release):
- All outputs 0, state IDLE, byte-lane valid mask 0.
- sdram_data is 0; unfilled buffer lanes read as PAD_BYTE.

States: IDLE, FILL, REQ, DRAIN.

IDLE:
- On ioctl_download rising, clear words_written and the mask, go to FILL.
- ioctl_wr is ignored in IDLE.

FILL, on ioctl_wr:
- Buffer word address = BASE_ADDR + ioctl_addr[24:2].
- Lane ioctl_addr[1:0] <= ioctl_data; set its mask bit.
- If the write sets lane 3, go to REQ next cycle.
- Non-sequential address: if mask != 0 and the new byte's word address differs from the buffered one, the byte is not taken:
  - ioctl_wait goes high in the same cycle, combinationally.
  - The partial word flushes through REQ.
  - The held byte is then captured into a fresh buffer.
  - hps_io holds ioctl_addr/ioctl_data while ioctl_wait is high.

REQ:
- sdram_req=1, sdram_we=1; addr and data stay stable until sdram_ack.
- ioctl_wait=1 throughout.
- On sdram_ack: deassert req the next cycle, words_written+1, mask cleared.
- Then return to FILL (download still high) or DRAIN (download low).
- Latency: lane-3 byte to sdram_req high = 1 cycle. Ack to ioctl_wait low = 1 cycle.

Download falls:
- In FILL with mask != 0: flush through REQ, then DRAIN.
- In FILL with mask == 0: go to DRAIN directly.
- In REQ: finish the pending write first.

DRAIN:
- Pulse done for 1 cycle, go to IDLE.

Other rules:
- Simultaneous ioctl_wr and ioctl_download fall: the byte is captured, then flushed.
- An ioctl_wr while in REQ is a protocol violation; it is ignored and the assertion flags it.
- Address wrap: the sum BASE_ADDR + ioctl_addr[24:2] is truncated to ADDR_WIDTH with no error.
- Reset mid-operation: abort immediately. sdram_req drops asynchronously and nothing is retried.
- A new ioctl_download rising while not in IDLE is ignored until IDLE is reached.

Test Plan:
- Sequential bytes 00..07 at addresses 0..7, ack 2 cycles after req → two writes: addr 0 data 32'h03020100, addr 1 data 32'h07060504; words_written=2; one done pulse.
- Bytes 0xAA,0xBB at addresses 0,1, then download low → one write 32'hFFFFBBAA at addr 0; done follows the ack.
- Bytes at 0x10,0x11 then a jump to 0x40 → flush of 32'hFFFF_xxxx at word 4, ioctl_wait held through it; the 0x40 byte lands in the word-0x10 buffer.
- Ack delayed 20 cycles → req, addr and data stable for all 20 cycles; ioctl_wait high throughout; no dropped byte.
- reset_n low during REQ → sdram_req=0 with no clock edge; after release a fresh download starts with words_written=0.
- BASE_ADDR=23'h7FFFFF, byte at ioctl_addr 4 → write to word address 0 (wrap).

Source files
------------

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader
//
// Bridges the hps_io byte-serial download port to the SDRAM controller
// request port. It packs download bytes into 32-bit little-endian words and
// writes each word through the req/ack handshake. While a write is pending,
// ioctl_wait holds off hps_io. This block owns the SDRAM write path only
// while ioctl_download is high; the game core keeps its read path.
//
// Ports:
//   clk             system clock (clk_sys, 48 MHz)
//   reset_n         asynchronous active-low reset
//   ioctl_addr      byte address of the current download byte
//   ioctl_data      download byte
//   ioctl_wr        one-cycle strobe: the byte is valid
//   ioctl_download  high for the whole download
//   ioctl_wait      high: hps_io must hold off the next ioctl_wr
//   sdram_addr      word address of the write
//   sdram_data      write word; lane n carries the byte from ioctl_addr[1:0]=n
//   sdram_we        write enable, high whenever sdram_req is high
//   sdram_req       write request, held until sdram_ack
//   sdram_ack       one-cycle pulse: the request was accepted
//   done            one-cycle pulse after the final word of a download
//   words_written   number of words committed in this download

module ioctl_sdram_loader #(
  parameter int                    ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [7:0]            PAD_BYTE   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  input  logic                  ioctl_download,
  output logic                  ioctl_wait,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [31:0]           sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic                  done,
  output logic [22:0]           words_written
);

  typedef enum logic [1:0] {IDLE, FILL, REQ, DRAIN} t_state;

  t_state                  state_reg, state_next;
  logic [3:0]              mask_reg, mask_next;
  logic [3:0][7:0]         lanes_reg, lanes_next;
  logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
  // A byte that arrived for a different word is parked here while the
  // partial word flushes, then it seeds the next buffer.
  logic                    pend_valid_reg, pend_valid_next;
  logic [1:0]              pend_lane_reg, pend_lane_next;
  logic [7:0]              pend_data_reg, pend_data_next;
  logic [ADDR_WIDTH-1:0]   pend_waddr_reg, pend_waddr_next;
  logic [22:0]             words_reg, words_next;
  logic [ADDR_WIDTH-1:0]   addr_out_reg;
  logic [31:0]             data_out_reg;
  logic                    req_reg;
  logic                    done_reg;

  logic [ADDR_WIDTH-1:0]   waddr_in;
  logic [1:0]              lane_in;
  logic [31:0]             fill_word;
  logic                    load_word;

  // The sum is truncated to ADDR_WIDTH, so addresses wrap silently.
  assign waddr_in = BASE_ADDR + ADDR_WIDTH'(ioctl_addr[24:2]);
  assign lane_in  = ioctl_addr[1:0];

  // The outgoing word is built from the post-update buffer, so the byte
  // accepted in this cycle is already included. Lanes that were never
  // written carry the pad value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign fill_word[8*gi +: 8] = mask_next[gi] ? lanes_next[gi] : PAD_BYTE;
    end
  endgenerate

  // The address/data registers are loaded only when a new request starts.
  // They stay frozen for as long as the controller withholds the ack.
  assign load_word = (state_next == REQ) && ((state_reg != REQ) || sdram_ack);

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    lanes_next      = lanes_reg;
    waddr_next      = waddr_reg;
    pend_valid_next = pend_valid_reg;
    pend_lane_next  = pend_lane_reg;
    pend_data_next  = pend_data_reg;
    pend_waddr_next = pend_waddr_reg;
    words_next      = words_reg;
    ioctl_wait      = 1'b0;

    case (state_reg)
      IDLE: begin
        // Level-sensitive: a download that rose while busy starts here.
        if (ioctl_download) begin
          state_next      = FILL;
          mask_next       = '0;
          words_next      = '0;
          pend_valid_next = 1'b0;
        end
      end

      FILL: begin
        if (ioctl_wr && (mask_reg != 4'd0) && (waddr_in != waddr_reg)) begin
          // Non-sequential byte. Stall hps_io in this same cycle, park the
          // byte, and flush the partial word first.
          ioctl_wait      = 1'b1;
          pend_valid_next = 1'b1;
          pend_lane_next  = lane_in;
          pend_data_next  = ioctl_data;
          pend_waddr_next = waddr_in;
          state_next      = REQ;
        end else begin
          if (ioctl_wr) begin
            lanes_next[lane_in] = ioctl_data;
            mask_next[lane_in]  = 1'b1;
            waddr_next          = waddr_in;
          end
          if (ioctl_wr && (lane_in == 2'd3)) begin
            state_next = REQ;
          end else if (!ioctl_download) begin
            state_next = (mask_next != 4'd0) ? REQ : DRAIN;
          end
        end
      end

      REQ: begin
        ioctl_wait = 1'b1;
        if (sdram_ack) begin
          words_next = words_reg + 23'd1;
          mask_next  = '0;
          if (pend_valid_reg) begin
            pend_valid_next            = 1'b0;
            lanes_next[pend_lane_reg]  = pend_data_reg;
            mask_next[pend_lane_reg]   = 1'b1;
            waddr_next                 = pend_waddr_reg;
            // A parked lane-3 byte, or a download that has already ended,
            // means the fresh buffer must be written out right away.
            state_next = ((pend_lane_reg == 2'd3) || !ioctl_download) ? REQ : FILL;
          end else begin
            state_next = ioctl_download ? FILL : DRAIN;
          end
        end
      end

      DRAIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      lanes_reg      <= '0;
      waddr_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_lane_reg  <= '0;
      pend_data_reg  <= '0;
      pend_waddr_reg <= '0;
      words_reg      <= '0;
      addr_out_reg   <= '0;
      data_out_reg   <= '0;
      req_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      lanes_reg      <= lanes_next;
      waddr_reg      <= waddr_next;
      pend_valid_reg <= pend_valid_next;
      pend_lane_reg  <= pend_lane_next;
      pend_data_reg  <= pend_data_next;
      pend_waddr_reg <= pend_waddr_next;
      words_reg      <= words_next;
      if (load_word) begin
        addr_out_reg <= waddr_next;
        data_out_reg <= fill_word;
      end
      req_reg        <= (state_next == REQ);
      done_reg       <= (state_next == DRAIN);
    end
  end

  assign sdram_addr    = addr_out_reg;
  assign sdram_data    = data_out_reg;
  assign sdram_req     = req_reg;
  assign sdram_we      = req_reg;
  assign done          = done_reg;
  assign words_written = words_reg;

  // A byte strobe while a write is in flight breaks the host handshake.
  // The byte is dropped.
  ap_no_wr_in_req: assert property (@(posedge clk) disable iff (!reset_n)
    !((state_reg == REQ) && ioctl_wr));

endmodule
